idu_pipe: RTL

Pipelined, buffered RV32I/RV32E instruction decode stage for the NPC core. It accepts fetched instructions over a valid/ready handshake into a small FIFO and decodes the head entry into register indices, immediate and control signals. It presents the result over a second valid/ready handshake to execute. It detects `ebreak` and illegal encodings and enters a sticky halt state that stops the simulation. It replaces the single-cycle combinational decoder between IFU and EXU.

---
 rtl/idu_pipe.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/idu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : idu_pipe
// Description : Buffered RV32I/RV32E decode stage with sticky ebreak/illegal halt.
// Revision    : 1.0 - initial release
// ============================================================================
module idu_pipe #(
    parameter int DEPTH = 2,
    parameter int RVE   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_funct3,
    output logic [31:0] out_imm,
    output logic [3:0]  out_alu_op,
    output logic        out_alu_src2,
    output logic        out_reg_wr,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic        out_ebreak,
    output logic        out_illegal,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [1:0]    cause_q, cause_d;

    logic        push, pop, head_vld;
    logic [31:0] inst, pc;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] d_imm;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [3:0]  d_alu_op;
    logic        d_src2, d_reg_wr, d_mem_rd, d_mem_wr, d_ebreak, d_illegal;
    logic        legal, use_rs1, use_rs2, use_rd, rve_bad;

    assign halted     = (state_q == ST_HALT);
    assign halt_cause = cause_q;
    assign head_vld   = (count_q != '0);
    assign in_ready   = (count_q < (AW+1)'(DEPTH)) && !halted && !flush;
    assign out_valid  = head_vld && !halted && !flush;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    assign inst = mem_q[rd_ptr_q][63:32];
    assign pc   = mem_q[rd_ptr_q][31:0];
    assign opc  = inst[6:0];
    assign f3   = inst[14:12];
    assign f7   = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'h000};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        d_imm    = '0;
        d_rs1    = inst[19:15];
        d_rs2    = inst[24:20];
        d_rd     = inst[11:7];
        d_alu_op = ALU_ADD;
        d_src2   = 1'b0;
        d_reg_wr = 1'b0;
        d_mem_rd = 1'b0;
        d_mem_wr = 1'b0;
        d_ebreak = 1'b0;
        legal    = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        case (opc)
            OPC_LUI: begin
                legal = 1'b1; d_imm = imm_u; d_alu_op = ALU_PASSB;
                d_src2 = 1'b1; d_reg_wr = 1'b1; use_rd = 1'b1;
            end
            OPC_AUIPC, OPC_JAL: begin
                legal = 1'b1; d_imm = (opc == OPC_JAL) ? imm_j : imm_u;
                d_src2 = 1'b1; d_reg_wr = 1'b1; use_rd = 1'b1;
            end
            OPC_JALR: begin
                legal = (f3 == 3'b000); d_imm = imm_i; d_src2 = 1'b1;
                d_reg_wr = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011); d_imm = imm_b;
                d_alu_op = ALU_SUB; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                d_imm = imm_i; d_src2 = 1'b1; d_reg_wr = 1'b1; d_mem_rd = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OPC_STORE: begin
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                d_imm = imm_s; d_src2 = 1'b1; d_mem_wr = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                legal = 1'b1; d_imm = imm_i; d_src2 = 1'b1; d_reg_wr = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
                case (f3)
                    3'b000: d_alu_op = ALU_ADD;
                    3'b001: begin d_alu_op = ALU_SLL; legal = (f7 == 7'h00); end
                    3'b010: d_alu_op = ALU_SLT;
                    3'b011: d_alu_op = ALU_SLTU;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b101: begin
                        d_alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                        legal    = (f7 == 7'h00) || (f7 == 7'h20);
                    end
                    3'b110: d_alu_op = ALU_OR;
                    default: d_alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                d_reg_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                legal = (f7 == 7'h00) ||
                        ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
                case (f3)
                    3'b000: d_alu_op = f7[5] ? ALU_SUB : ALU_ADD;
                    3'b001: d_alu_op = ALU_SLL;
                    3'b010: d_alu_op = ALU_SLT;
                    3'b011: d_alu_op = ALU_SLTU;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b101: d_alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: d_alu_op = ALU_OR;
                    default: d_alu_op = ALU_AND;
                endcase
            end
            OPC_SYSTEM: begin
                if (inst == 32'h0010_0073) begin
                    legal = 1'b1; d_ebreak = 1'b1;
                    d_rs1 = 5'd0; d_rs2 = 5'd0; d_rd = 5'd10;
                end
            end
            default: legal = 1'b0;
        endcase
        rve_bad   = (RVE != 0) && ((use_rs1 && inst[19]) || (use_rs2 && inst[24]) ||
                                   (use_rd && inst[11]));
        d_illegal = !legal || rve_bad;
        if (d_illegal) begin
            d_alu_op = ALU_ADD;
            d_src2   = 1'b0;
            d_reg_wr = 1'b0;
            d_mem_rd = 1'b0;
            d_mem_wr = 1'b0;
            d_ebreak = 1'b0;
        end
    end

    // An empty FIFO presents all-zero decode instead of whatever stale slot sits at the head.
    always_comb begin
        out_pc       = head_vld ? pc        : '0;
        out_rs1      = head_vld ? d_rs1     : '0;
        out_rs2      = head_vld ? d_rs2     : '0;
        out_rd       = head_vld ? d_rd      : '0;
        out_funct3   = head_vld ? f3        : '0;
        out_imm      = head_vld ? d_imm     : '0;
        out_alu_op   = head_vld ? d_alu_op  : '0;
        out_alu_src2 = head_vld && d_src2;
        out_reg_wr   = head_vld && d_reg_wr;
        out_mem_rd   = head_vld && d_mem_rd;
        out_mem_wr   = head_vld && d_mem_wr;
        out_ebreak   = head_vld && d_ebreak;
        out_illegal  = head_vld && d_illegal;
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop && (out_ebreak || out_illegal)) begin
            state_d  = ST_HALT;
            cause_d  = out_ebreak ? 2'b01 : 2'b10;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cause_q  <= 2'b00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_inst, in_pc};
    end

endmodule
`default_nettype wire
